// File: rtl/trace_checker.sv
// trace_checker: captures CPU writeback events into a small FIFO and compares
// them, in order, against a golden trace stream. Reports a pass count, the first
// error (mismatch or FIFO overflow) and a clean end-of-test indication.
// Optional build macro: TRACE_CHECK_BYTE_MASK_EN -- when defined, writeback data
// is compared only in byte lanes whose captured write-enable bit is set.
module trace_checker #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] END_PC     = 32'hbfc00100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        open_trace,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_wen,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic        ref_valid,
    output logic        ref_ready,
    input  logic [31:0] ref_pc,
    input  logic [4:0]  ref_wnum,
    input  logic [31:0] ref_wdata,
    output logic [31:0] pass_cnt,
    output logic [1:0]  err_code,
    output logic [31:0] err_pc,
    output logic [31:0] err_exp_wdata,
    output logic [31:0] err_got_wdata,
    output logic        done,
    output logic        error
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // FIFO storage, one array per captured field
    logic [31:0] mem_pc    [FIFO_DEPTH];
    logic [4:0]  mem_wnum  [FIFO_DEPTH];
    logic [31:0] mem_wdata [FIFO_DEPTH];
`ifdef TRACE_CHECK_BYTE_MASK_EN
    logic [3:0]  mem_wen   [FIFO_DEPTH];
    logic [3:0]  head_wen;
`endif

    // Pointers carry one extra MSB so full and empty are distinguishable
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          fifo_empty;
    logic          fifo_full;
    logic          end_flag;

    logic          cap_ev;
    logic          end_ev;
    logic          pop;
    logic          push;
    logic          mismatch;
    logic          overflow;
    logic [31:0]   head_pc;
    logic [4:0]    head_wnum;
    logic [31:0]   head_wdata;
    logic [31:0]   cmp_mask;

`ifdef TRACE_CHECK_BYTE_MASK_EN
    // Expand per-byte write enables into a 32-bit compare mask
    function automatic logic [31:0] lane_mask(input logic [3:0] wen);
        lane_mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    endfunction
`endif

    // A FIFO head matches the golden entry when pc, register and masked data agree
    function automatic logic entry_match(
        input logic [31:0] h_pc,
        input logic [4:0]  h_wnum,
        input logic [31:0] h_wdata,
        input logic [31:0] r_pc,
        input logic [4:0]  r_wnum,
        input logic [31:0] r_wdata,
        input logic [31:0] mask
    );
        entry_match = (h_pc == r_pc) && (h_wnum == r_wnum) &&
                      ((h_wdata & mask) == (r_wdata & mask));
    endfunction

    assign wr_idx     = wr_ptr[AW-1:0];
    assign rd_idx     = rd_ptr[AW-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    assign head_pc    = mem_pc[rd_idx];
    assign head_wnum  = mem_wnum[rd_idx];
    assign head_wdata = mem_wdata[rd_idx];

`ifdef TRACE_CHECK_BYTE_MASK_EN
    assign head_wen   = mem_wen[rd_idx];
    assign cmp_mask   = lane_mask(head_wen);
`else
    assign cmp_mask   = 32'hFFFF_FFFF;
`endif

    // A register write with a nonzero destination is a traced event; the end PC
    // is recognised even for writes to r0 or with no byte enables
    assign cap_ev    = (state == RUN) && open_trace && (|debug_wb_rf_wen) &&
                       (debug_wb_rf_wnum != 5'd0);
    assign end_ev    = (state == RUN) && open_trace && (debug_wb_pc == END_PC);

    assign ref_ready = (state == RUN) && !fifo_empty;
    assign pop       = ref_valid && ref_ready;
    assign mismatch  = pop && !entry_match(head_pc, head_wnum, head_wdata,
                                           ref_pc, ref_wnum, ref_wdata, cmp_mask);
    // Full is only a problem if nothing leaves in the same cycle
    assign overflow  = cap_ev && fifo_full && !pop;
    assign push      = cap_ev && !overflow;

    // FIFO storage writes; data arrays are not reset, only the pointers are
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_idx]    <= debug_wb_pc;
            mem_wnum[wr_idx]  <= debug_wb_rf_wnum;
            mem_wdata[wr_idx] <= debug_wb_rf_wdata;
`ifdef TRACE_CHECK_BYTE_MASK_EN
            mem_wen[wr_idx]   <= debug_wb_rf_wen;
`endif
        end
    end

    // Control FSM, FIFO pointers, pass counter and first-error capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            end_flag      <= 1'b0;
            pass_cnt      <= 32'd0;
            err_code      <= 2'd0;
            err_pc        <= 32'd0;
            err_exp_wdata <= 32'd0;
            err_got_wdata <= 32'd0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (end_ev) begin
                end_flag <= 1'b1;
            end
            if (pop && !mismatch) begin
                pass_cnt <= pass_cnt + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (open_trace) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Mismatch outranks overflow; errors outrank completion
                    if (mismatch) begin
                        state         <= ERROR;
                        err_code      <= 2'd1;
                        err_pc        <= head_pc;
                        err_exp_wdata <= ref_wdata;
                        err_got_wdata <= head_wdata;
                        error         <= 1'b1;
                    end else if (overflow) begin
                        state    <= ERROR;
                        err_code <= 2'd2;
                        err_pc   <= debug_wb_pc;
                        error    <= 1'b1;
                    end else if (end_flag && fifo_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    // ERROR and DONE hold until reset
                end
            endcase
        end
    end

endmodule
